// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller:
// segment codes {a..g,dp}, controller FSM states and BCD sizing helper.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'b11111100;
  localparam logic [7:0] SEG_1     = 8'b01100000;
  localparam logic [7:0] SEG_2     = 8'b11011010;
  localparam logic [7:0] SEG_3     = 8'b11110010;
  localparam logic [7:0] SEG_4     = 8'b01100110;
  localparam logic [7:0] SEG_5     = 8'b10110110;
  localparam logic [7:0] SEG_6     = 8'b10111110;
  localparam logic [7:0] SEG_7     = 8'b11100000;
  localparam logic [7:0] SEG_8     = 8'b11111110;
  localparam logic [7:0] SEG_9     = 8'b11110110;
  localparam logic [7:0] SEG_DASH  = 8'b00000010;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  function automatic int bcd_digits(input int w);
    return (w + 2) / 3;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, DATA_W steps.
// done is high during the final step; bcd holds the full result after that edge.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_W-1:0]                 bin,
  output logic                              busy,
  output logic                              done,
  output logic [4*bcd_digits(DATA_W)-1:0]   bcd
);

  localparam int BCD_N = bcd_digits(DATA_W);
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  adj;

  assign done = busy && (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
      bcd   <= '0;
    end else if (!busy) begin
      if (start) begin
        shreg <= bin;
        bcd   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end
    end else begin
      shreg <= shreg << 1;
      bcd   <= BCD_W'({adj, shreg[DATA_W-1]});
      cnt   <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multiplexed signed seven-segment display controller with double-dabble conversion.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  value_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic [7:0]            segment_select
);

  localparam int BCD_N = bcd_digits(DATA_W);
  localparam int MAG_N = NUM_DIGITS - 1;
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_t              state;
  logic                neg_cap;
  logic                disp_neg;
  logic [4*MAG_N-1:0]  disp_nib;
  logic [4*MAG_N-1:0]  mag_nib;
  logic                over_range;
  logic [4*BCD_N-1:0]  conv_bcd;
  logic                conv_busy;
  logic                conv_done;
  logic                start;
  logic [DATA_W-1:0]   magnitude;
  logic [CNT_W-1:0]    refresh_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [3:0]          cur_nib;

  assign start     = (state == ST_IDLE) && value_valid;
  // Unsigned negate keeps the most negative value exact.
  assign magnitude = value_i[DATA_W-1] ? ('0 - value_i) : value_i;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (magnitude),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    mag_nib    = '0;
    over_range = 1'b0;
    for (int unsigned i = 0; i < MAG_N && i < BCD_N; i++) begin
      mag_nib[4*i +: 4] = conv_bcd[4*i +: 4];
    end
    for (int unsigned i = MAG_N; i < BCD_N; i++) begin
      if (conv_bcd[4*i +: 4] != 4'd0) over_range = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      neg_cap  <= 1'b0;
      disp_neg <= 1'b0;
      disp_nib <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (value_valid) begin
            neg_cap <= value_i[DATA_W-1];
            busy    <= 1'b1;
            state   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          // Leave on the final shift; an idle converter here means the start was lost.
          if (conv_done || !conv_busy) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_nib <= mag_nib;
          disp_neg <= neg_cap;
          overflow <= over_range;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic leading;
`endif

  always_comb begin
    digit_select = NUM_DIGITS'(1) << scan_idx;
    cur_nib      = '0;
`ifdef SEG7_LZ_BLANK_EN
    leading      = 1'b1;
`endif
    for (int unsigned i = 0; i < MAG_N; i++) begin
      if (i == 32'(scan_idx)) cur_nib = disp_nib[4*i +: 4];
`ifdef SEG7_LZ_BLANK_EN
      if (i >= 32'(scan_idx) && disp_nib[4*i +: 4] != 4'd0) leading = 1'b0;
`endif
    end

    if (32'(scan_idx) == MAG_N)
      segment_select = disp_neg ? SEG_DASH : SEG_BLANK;
    else if (overflow)
      segment_select = SEG_DASH;
`ifdef SEG7_LZ_BLANK_EN
    else if (leading && scan_idx != '0)
      segment_select = SEG_BLANK;
`endif
    else
      segment_select = seg_code(cur_nib);
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed self-checking bench for seg7_display_ctrl (DATA_W=32, 4 digits, REFRESH_DIV=4).
module tb_seg7_display_ctrl;

  localparam logic [7:0] S0 = 8'b11111100;
  localparam logic [7:0] S1 = 8'b01100000;
  localparam logic [7:0] S2 = 8'b11011010;
  localparam logic [7:0] S3 = 8'b11110010;
  localparam logic [7:0] S4 = 8'b01100110;
  localparam logic [7:0] S5 = 8'b10110110;
  localparam logic [7:0] S7 = 8'b11100000;
  localparam logic [7:0] S9 = 8'b11110110;
  localparam logic [7:0] SD = 8'b00000010;
  localparam logic [7:0] SB = 8'b00000000;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [7:0] LZ0 = SB;
`else
  localparam logic [7:0] LZ0 = S0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value_i = '0;
  logic        value_valid = 1'b0;
  logic        busy;
  logic        overflow;
  logic [3:0]  digit_select;
  logic [7:0]  segment_select;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_display_ctrl #(.DATA_W(32), .NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .value_i        (value_i),
    .value_valid    (value_valid),
    .busy           (busy),
    .overflow       (overflow),
    .digit_select   (digit_select),
    .segment_select (segment_select)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input int idx, input logic [7:0] exp, input string tag);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    for (int i = 0; i < 20 && digit_select !== sel; i++) tick();
    check({tag, "_sel"}, 32'(digit_select), 32'(sel));
    check(tag, 32'(segment_select), 32'(exp));
  endtask

  task automatic show_all(input logic [7:0] s, input logic [7:0] h, input logic [7:0] t,
                          input logic [7:0] u, input string tag);
    show(0, u, {tag, "_units"});
    show(1, t, {tag, "_tens"});
    show(2, h, {tag, "_hundreds"});
    show(3, s, {tag, "_sign"});
  endtask

  task automatic convert(input logic [31:0] v, input string tag);
    bit held;
    held = 1'b1;
    value_i = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (busy !== 1'b1) held = 1'b0;
      tick();
    end
    check({tag, "_busy_window"}, 32'(held), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_sel", 32'(digit_select), 32'b0001);
    check("rst_seg", 32'(segment_select), 32'(S0));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    repeat (4) tick();
    check("scan_1", 32'(digit_select), 32'b0010);
    repeat (4) tick();
    check("scan_2", 32'(digit_select), 32'b0100);
    repeat (4) tick();
    check("scan_3", 32'(digit_select), 32'b1000);
    repeat (4) tick();
    check("scan_wrap", 32'(digit_select), 32'b0001);

    convert(32'd123, "v123");
    check("v123_ovf", 32'(overflow), 32'd0);
    show_all(SB, S1, S2, S3, "v123");

    convert(32'hFFFF_FFD3, "vm45");
    show_all(SD, LZ0, S4, S5, "vm45");

    convert(32'd5, "v5");
    show_all(SB, LZ0, LZ0, S5, "v5");

    convert(32'd999, "v999");
    check("v999_ovf", 32'(overflow), 32'd0);
    show_all(SB, S9, S9, S9, "v999");

    convert(32'd1000, "v1000");
    check("v1000_ovf", 32'(overflow), 32'd1);
    show_all(SB, SD, SD, SD, "v1000");

    // Load 7, then offer 321 mid-conversion and again during COMMIT.
    value_i = 32'd7;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (4) tick();
    value_i = 32'd321;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (27) tick();
    check("ign_commit_busy", 32'(busy), 32'd1);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    check("ign_busy_done", 32'(busy), 32'd0);
    tick();
    check("ign_not_accepted", 32'(busy), 32'd0);
    check("ign_ovf", 32'(overflow), 32'd0);
    show_all(SB, LZ0, LZ0, S7, "ign");

    convert(32'h8000_0000, "vmin");
    check("vmin_ovf", 32'(overflow), 32'd1);
    show_all(SD, SD, SD, SD, "vmin");

    // Reset at T+10 of a new conversion.
    value_i = 32'd888;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (9) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_sel", 32'(digit_select), 32'b0001);
    check("mid_rst_seg", 32'(segment_select), 32'(S0));
    repeat (40) tick();
    check("mid_rst_idle", 32'(busy), 32'd0);
    show_all(SB, LZ0, LZ0, S0, "mid_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
